// File: rtl/vispack_pkg.sv
// Shared correlator constants for the visibility packer: default widths and FSM state encodings.
package vispack_pkg;

    localparam int unsigned IBITS_DEF  = 8;
    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned FDEPTH_DEF = 16;
    localparam int unsigned FBITS_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/vispack_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head entry whenever the FIFO is non-empty.
module vispack_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ABITS = 4
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           push,
    input  logic [W-1:0]   din,
    input  logic           pop,
    output logic [W-1:0]   dout,
    output logic [ABITS:0] count,
    output logic           full,
    output logic           empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (ABITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head word reads as zero out of reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + ABITS'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ABITS'(1);
            end
            count <= count + (ABITS+1)'(push_ok) - (ABITS+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/vispack.sv
// Visibility packer: frames of IBITS values packed little-endian into WIDTH-bit stream words.
// Optional counters enabled by defining VISPACK_COUNT_EN.
module vispack
    import vispack_pkg::*;
#(
    parameter int unsigned IBITS  = IBITS_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned FDEPTH = FDEPTH_DEF,
    parameter int unsigned FBITS  = FBITS_DEF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             first_i,
    input  logic             last_i,
    input  logic [IBITS-1:0] data_i,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [WIDTH-1:0] m_tdata,
    output logic             overflow_o,
    output logic [15:0]      frames_o,
    output logic [15:0]      drops_o
);

    localparam int unsigned RATIO = WIDTH / IBITS;
    localparam int unsigned LBITS = $clog2(RATIO);

    logic             v_q, f_q, l_q;
    logic [IBITS-1:0] d_q;

    state_e           state, state_n;
    logic [LBITS-1:0] lane, lane_n, lane_eff;
    logic [WIDTH-1:0] acc, acc_n, acc_eff, word_c;
    logic             pack_en, push, frame_err, drop_ev;

    logic             fifo_full, fifo_empty;
    logic [FBITS:0]   fifo_count;

    // Registered input stage; first/last are qualified by valid here.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= valid_i;
            f_q <= valid_i && first_i;
            l_q <= valid_i && last_i;
            d_q <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            lane  <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            acc   <= acc_n;
        end
    end

    // A first beat anywhere restarts packing at lane 0 with an empty accumulator.
    always_comb begin
        state_n   = state;
        lane_n    = lane;
        acc_n     = acc;
        lane_eff  = lane;
        acc_eff   = acc;
        pack_en   = 1'b0;
        push      = 1'b0;
        frame_err = 1'b0;
        drop_ev   = 1'b0;
        if (v_q) begin
            case (state)
                ST_IDLE: begin
                    if (f_q) begin
                        pack_en  = 1'b1;
                        lane_eff = '0;
                        acc_eff  = '0;
                    end
                end
                ST_PACK: begin
                    pack_en = 1'b1;
                    if (f_q) begin
                        frame_err = 1'b1;
                        lane_eff  = '0;
                        acc_eff   = '0;
                    end
                end
                ST_DROP: begin
                    if (f_q) begin
                        frame_err = 1'b1;
                        pack_en   = 1'b1;
                        lane_eff  = '0;
                        acc_eff   = '0;
                    end else if (l_q) begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        word_c = acc_eff;
        word_c[lane_eff*IBITS +: IBITS] = d_q;
        if (pack_en) begin
            if (lane_eff == LBITS'(RATIO - 1) || l_q) begin
                lane_n = '0;
                acc_n  = '0;
                if (fifo_full) begin
                    drop_ev = 1'b1;
                    state_n = l_q ? ST_IDLE : ST_DROP;
                end else begin
                    push    = 1'b1;
                    state_n = l_q ? ST_IDLE : ST_PACK;
                end
            end else begin
                acc_n   = word_c;
                lane_n  = lane_eff + LBITS'(1);
                state_n = ST_PACK;
            end
        end
    end

    vispack_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (FDEPTH),
        .ABITS (FBITS)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .din   ({l_q, word_c}),
        .pop   (m_tvalid && m_tready),
        .dout  ({m_tlast, m_tdata}),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_tvalid = !fifo_empty;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (drop_ev || frame_err) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef VISPACK_COUNT_EN
    // A framing error and a full-FIFO drop in the same beat count as two drops.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            frames_o <= '0;
            drops_o  <= '0;
        end else begin
            frames_o <= frames_o + 16'(push && l_q);
            drops_o  <= drops_o + 16'(drop_ev) + 16'(frame_err);
        end
    end
`else
    assign frames_o = '0;
    assign drops_o  = '0;
`endif

endmodule

// File: tb/tb_vispack.sv
// Scoreboard bench for vispack: expected words queued at drive time, checked as they leave the stream.
module tb_vispack;

    logic        clock;
    logic        rst_n;
    logic        valid_i, first_i, last_i;
    logic [7:0]  data_i;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic        overflow_o;
    logic [15:0] frames_o, drops_o;

    int          n_tests;
    int          n_fail;
    logic [32:0] sb [$];

`ifdef VISPACK_COUNT_EN
    localparam logic [15:0] DROP_EXP  = 16'd1;
    localparam logic [15:0] FRAME_EXP = 16'd1;
`else
    localparam logic [15:0] DROP_EXP  = 16'd0;
    localparam logic [15:0] FRAME_EXP = 16'd0;
`endif

    vispack dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .first_i    (first_i),
        .last_i     (last_i),
        .data_i     (data_i),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .overflow_o (overflow_o),
        .frames_o   (frames_o),
        .drops_o    (drops_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_beat(input logic v, input logic f, input logic l, input logic [7:0] d);
        @(posedge clock);
        #1;
        valid_i = v;
        first_i = f;
        last_i  = l;
        data_i  = d;
    endtask

    // Queue the expected words of an n-value frame; only the first `keep` words survive.
    task automatic send_frame(input int n, input logic [7:0] base, input int keep);
        logic [31:0] w;
        logic [7:0]  d;
        logic        lastb;
        int          lane;
        int          widx;
        w = '0;
        lane = 0;
        widx = 0;
        for (int i = 0; i < n; i++) begin
            d = 8'(int'(base) + i);
            lastb = (i == n - 1);
            w[lane*8 +: 8] = d;
            if (lane == 3 || lastb) begin
                if (widx < keep) sb.push_back({lastb, w});
                widx++;
                w = '0;
                lane = 0;
            end else begin
                lane++;
            end
            drive_beat(1'b1, i == 0, lastb, d);
        end
        drive_beat(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || m_tvalid) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("drain_timeout", 64'(k < budget), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // Output monitor: every transferred word must match the head of the scoreboard.
    always @(negedge clock) begin
        logic [32:0] exp;
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(m_tdata), 64'hDEAD_0000_0000);
            end else begin
                exp = sb.pop_front();
                check("tdata", 64'(m_tdata), 64'(exp[31:0]));
                check("tlast", 64'(m_tlast), 64'(exp[32]));
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        first_i  = 1'b0;
        last_i   = 1'b0;
        data_i   = 8'h00;
        m_tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_frames", 64'(frames_o), 64'd0);
        check("rst_drops", 64'(drops_o), 64'd0);
        rst_n = 1'b1;

        // 8-value frame with latency probe around the 4th beat
        sb.push_back({1'b0, 32'h0403_0201});
        sb.push_back({1'b1, 32'h0807_0605});
        drive_beat(1'b1, 1'b1, 1'b0, 8'h01);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h02);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h03);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h04);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h05);
        @(negedge clock);
        check("lat_edge1_tvalid", 64'(m_tvalid), 64'd0);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h06);
        @(negedge clock);
        check("lat_edge2_tvalid", 64'(m_tvalid), 64'd1);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h07);
        drive_beat(1'b1, 1'b0, 1'b1, 8'h08);
        drive_beat(1'b0, 1'b0, 1'b0, 8'h00);
        drain(50);

        // partial last word, then back-to-back single-value frames
        send_frame(5, 8'hA0, 99);
        drain(50);
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b1, 32'h0000_005A});
            drive_beat(1'b1, 1'b1, 1'b1, 8'h5A);
        end
        drive_beat(1'b0, 1'b0, 1'b0, 8'h00);
        drain(50);
        check("no_overflow_yet", 64'(overflow_o), 64'd0);

        // overflow: 17 words plus a tail with the stream stalled
        m_tready = 1'b0;
        send_frame(76, 8'h10, 16);
        repeat (2) @(negedge clock);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_drops", 64'(drops_o), 64'(DROP_EXP));
        check("ovf_tvalid", 64'(m_tvalid), 64'd1);
        check("ovf_queued", 64'(sb.size()), 64'd16);
        m_tready = 1'b1;
        drain(100);
        send_frame(8, 8'hC0, 99);
        drain(50);

        // framing error: first_i after two values of an open frame
        do_reset();
        drive_beat(1'b1, 1'b1, 1'b0, 8'h11);
        drive_beat(1'b1, 1'b0, 1'b0, 8'h22);
        send_frame(4, 8'h31, 99);
        drain(50);
        check("ferr_overflow", 64'(overflow_o), 64'd1);
        check("ferr_drops", 64'(drops_o), 64'(DROP_EXP));

        // reset mid-frame with three words queued
        m_tready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive_beat(1'b1, i == 0, 1'b0, 8'(8'h60 + i));
        end
        drive_beat(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clock);
        check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_overflow", 64'(overflow_o), 64'd0);
        rst_n = 1'b1;
        m_tready = 1'b1;
        send_frame(4, 8'hB0, 99);
        drain(50);
        check("post_rst_frames", 64'(frames_o), 64'(FRAME_EXP));
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
